// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory round-robin scheduler and
// the memory subsystem it feeds.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } sched_state_t;

    typedef enum logic [1:0] {
        I = 2'b00,
        M = 2'b01,
        S = 2'b10
    } coherency_t;

    localparam int unsigned DefNumReq     = 4;
    localparam int unsigned DefDataSize   = 2;
    localparam int unsigned DefAddrW      = 14;
    localparam int unsigned DefTimeoutCyc = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping, found by rotating a doubled copy of the request vector.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       any_req
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] rot;
    logic                 found;
    int unsigned          idx;

    always_comb begin
        dbl     = {req, req};
        rot     = dbl >> ptr;
        found   = 1'b0;
        idx     = 0;
        win_idx = '0;
        any_req = |req;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                idx   = int'(ptr) + i;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                win_idx = IdxW'(idx);
            end
        end
        winner = any_req ? (NUM_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/mem_rr_scheduler.sv
// Round-robin scheduler sharing one memory port among NUM_REQ requesters:
// latch a request, issue a one-cycle command, await ack or timeout, respond.
module mem_rr_scheduler
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DefNumReq,
    parameter int unsigned DATA_SIZE   = DefDataSize,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_W-1:0]     addr,
    input  logic [NUM_REQ*DATA_SIZE*8-1:0] wdata,
    output logic [NUM_REQ-1:0]            resp,
    output logic [DATA_SIZE*8-1:0]        rdata,
    output logic                          err,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_SIZE*8-1:0]        mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_SIZE*8-1:0]        mem_rdata
);

    localparam int unsigned DW   = DATA_SIZE * 8;
    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

    sched_state_t    state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] gidx_q, gidx_d;
    logic            we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IdxW-1:0]    pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] gnt_onehot;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (pick_onehot),
        .win_idx (pick_idx),
        .any_req (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gidx_d  = pick_idx;
                    we_d    = we[pick_idx];
                    addr_d  = addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = wdata[pick_idx*DW +: DW];
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // An ack landing in the timeout cycle still completes cleanly.
                if (mem_ack) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d   = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        busy       = (state_q != IDLE);
        gnt_onehot = NUM_REQ'(1) << gidx_q;
        grant      = busy ? gnt_onehot : '0;
        mem_req    = (state_q == ISSUE);
        mem_we     = busy & we_q;
        mem_addr   = busy ? addr_q : '0;
        mem_wdata  = busy ? wdata_q : '0;
        resp       = (state_q == RESP) ? gnt_onehot : '0;
        rdata      = (state_q == RESP) ? rdata_q : '0;
        err        = (state_q == RESP) & err_q;
    end

endmodule
